// File: rtl/multi_debouncer.sv
// multi_debouncer: debounces Channels independent asynchronous inputs into
// clean registered levels with one-cycle rise/fall pulses per channel.
// Each input passes through a SyncStages-deep synchroniser, and a per-channel
// stability counter advances on CountEnable while the synchronised input
// differs from the debounced level.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat pulses while a
// channel is held high; RepeatPulse is tied to zero when undefined).
module multi_debouncer #(
    parameter int   Channels     = 4,
    parameter int   CounterWidth = 8,
    parameter int   DebounceTime = 200,
    parameter int   SyncStages   = 2,
    parameter logic InitValue    = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int   RepeatDelay  = 100,
    parameter int   RepeatPeriod = 25
`endif
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                CountEnable,
    input  logic [Channels-1:0] DataIn,
    output logic [Channels-1:0] DataOut,
    output logic [Channels-1:0] RisePulse,
    output logic [Channels-1:0] FallPulse,
    output logic [Channels-1:0] RepeatPulse
);

    localparam logic [CounterWidth-1:0] CountMax = CounterWidth'(DebounceTime - 1);
    localparam logic [CounterWidth-1:0] CountOne = CounterWidth'(1);

    logic [Channels-1:0]     sync_q [SyncStages];
    logic [Channels-1:0]     syncOut;
    logic [CounterWidth-1:0] count_q [Channels];
    logic [CounterWidth-1:0] count_d [Channels];
    logic [Channels-1:0]     dataOut_q, dataOut_d;
    logic [Channels-1:0]     rise_q, rise_d;
    logic [Channels-1:0]     fall_q, fall_d;

    assign syncOut = sync_q[SyncStages-1];

    // Synchroniser chain; every stage powers up at the reset level so no
    // spurious edge is seen right after reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= {Channels{InitValue}};
            end
        end else begin
            sync_q[0] <= DataIn;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Stability window: any agreement with the current level restarts it,
    // a full window of enabled disagreement commits the new level and pulses.
    always_comb begin
        dataOut_d = dataOut_q;
        rise_d    = '0;
        fall_d    = '0;
        for (int n = 0; n < Channels; n++) begin
            count_d[n] = count_q[n];
            if (syncOut[n] == dataOut_q[n]) begin
                count_d[n] = '0;
            end else if (CountEnable) begin
                if (count_q[n] == CountMax) begin
                    dataOut_d[n] = syncOut[n];
                    count_d[n]   = '0;
                    rise_d[n]    = syncOut[n];
                    fall_d[n]    = ~syncOut[n];
                end else begin
                    count_d[n] = count_q[n] + CountOne;
                end
            end
        end
    end

    // Debounced level, counters and edge pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dataOut_q <= {Channels{InitValue}};
            rise_q    <= '0;
            fall_q    <= '0;
            for (int n = 0; n < Channels; n++) begin
                count_q[n] <= '0;
            end
        end else begin
            dataOut_q <= dataOut_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            for (int n = 0; n < Channels; n++) begin
                count_q[n] <= count_d[n];
            end
        end
    end

    assign DataOut   = dataOut_q;
    assign RisePulse = rise_q;
    assign FallPulse = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CounterWidth-1:0] DelayMax  = CounterWidth'(RepeatDelay - 1);
    localparam logic [CounterWidth-1:0] PeriodMax = CounterWidth'(RepeatPeriod - 1);

    logic [CounterWidth-1:0] repCount_q [Channels];
    logic [CounterWidth-1:0] repCount_d [Channels];
    logic [Channels-1:0]     repPhase_q, repPhase_d;
    logic [Channels-1:0]     repPulse_q, repPulse_d;

    // Auto-repeat: first pulse after the initial delay, then one per period;
    // everything clears as soon as the channel is (or is about to be) low.
    always_comb begin
        repPhase_d = repPhase_q;
        repPulse_d = '0;
        for (int n = 0; n < Channels; n++) begin
            repCount_d[n] = repCount_q[n];
            if (!dataOut_q[n] || !dataOut_d[n]) begin
                repCount_d[n] = '0;
                repPhase_d[n] = 1'b0;
            end else if (CountEnable) begin
                if (repCount_q[n] == (repPhase_q[n] ? PeriodMax : DelayMax)) begin
                    repPulse_d[n] = 1'b1;
                    repCount_d[n] = '0;
                    repPhase_d[n] = 1'b1;
                end else begin
                    repCount_d[n] = repCount_q[n] + CountOne;
                end
            end
        end
    end

    // Repeat counters, phase flags and registered repeat pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            repPhase_q <= '0;
            repPulse_q <= '0;
            for (int n = 0; n < Channels; n++) begin
                repCount_q[n] <= '0;
            end
        end else begin
            repPhase_q <= repPhase_d;
            repPulse_q <= repPulse_d;
            for (int n = 0; n < Channels; n++) begin
                repCount_q[n] <= repCount_d[n];
            end
        end
    end

    assign RepeatPulse = repPulse_q;
`else
    assign RepeatPulse = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Testbench for multi_debouncer (Channels=2, CounterWidth=2, DebounceTime=3,
// SyncStages=2). A behavioural model tracks, per channel, how many enabled
// cycles the synchronised input has disagreed with the debounced level.
module tb_multi_debouncer;

    localparam int CH = 2;
    localparam int DT = 3;
    localparam int SS = 2;
    localparam int RD = 3;
    localparam int RP = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          CountEnable;
    logic [CH-1:0] DataIn;
    logic [CH-1:0] DataOut, RisePulse, FallPulse, RepeatPulse;

    int checks   = 0;
    int failures = 0;

    logic [CH-1:0] mSync [SS];
    logic [CH-1:0] mOut, mRise, mFall, mRep;
    int            mRun [CH];
    int            mRepCnt [CH];

    multi_debouncer #(
        .Channels    (CH),
        .CounterWidth(2),
        .DebounceTime(DT),
        .SyncStages  (SS),
        .InitValue   (1'b0)
`ifdef DEBOUNCE_REPEAT_EN
        ,
        .RepeatDelay (RD),
        .RepeatPeriod(RP)
`endif
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CountEnable(CountEnable),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .RisePulse  (RisePulse),
        .FallPulse  (FallPulse),
        .RepeatPulse(RepeatPulse)
    );

    always #5 Clk = ~Clk;

    task automatic resetModel();
        for (int i = 0; i < SS; i++) mSync[i] = '0;
        mOut = '0; mRise = '0; mFall = '0; mRep = '0;
        for (int n = 0; n < CH; n++) begin
            mRun[n] = 0;
            mRepCnt[n] = 0;
        end
    endtask

    // Advance model by one rising edge using pre-edge inputs, then the DUT.
    task automatic tick();
        logic [CH-1:0] s, nOut;
        s = mSync[SS-1];
        nOut = mOut;
        mRise = '0; mFall = '0; mRep = '0;
        for (int n = 0; n < CH; n++) begin
            if (s[n] == mOut[n]) begin
                mRun[n] = 0;
            end else if (CountEnable) begin
                mRun[n]++;
                if (mRun[n] == DT) begin
                    nOut[n] = s[n];
                    mRun[n] = 0;
                    if (s[n]) mRise[n] = 1'b1;
                    else      mFall[n] = 1'b1;
                end
            end
`ifdef DEBOUNCE_REPEAT_EN
            if (!nOut[n]) begin
                mRepCnt[n] = 0;
            end else if (mOut[n] && CountEnable) begin
                mRepCnt[n]++;
                if (mRepCnt[n] == RD || (mRepCnt[n] > RD && (mRepCnt[n] - RD) % RP == 0))
                    mRep[n] = 1'b1;
            end
`endif
        end
        mOut = nOut;
        for (int i = SS - 1; i > 0; i--) mSync[i] = mSync[i-1];
        mSync[0] = DataIn;
        @(posedge Clk);
        #1;
    endtask

    task automatic settle(input logic [CH-1:0] level);
        DataIn = level;
        CountEnable = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        DataIn = 2'b11;
        CountEnable = 1'b1;
        resetModel();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %b required %b", {DataOut, RisePulse, FallPulse, RepeatPulse}, 8'h00);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({DataOut, RisePulse, FallPulse} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got %b required %b", {DataOut, RisePulse, FallPulse}, 6'b0);
        end
    endtask

    task automatic test_clean_rise();
        settle(2'b00);
        DataIn = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== {mOut, mRise, mFall, mRep}) begin
                failures++;
                $display("[TB] FAIL rise_model edge %0d: got %b required %b", e, {DataOut, RisePulse, FallPulse, RepeatPulse}, {mOut, mRise, mFall, mRep});
            end
            checks++;
            if ({DataOut, RisePulse} !== ((e < 5) ? 4'b0000 : (e == 5) ? 4'b0101 : 4'b0100)) begin
                failures++;
                $display("[TB] FAIL rise_edge %0d: got %b required %b", e, {DataOut, RisePulse}, ((e < 5) ? 4'b0000 : (e == 5) ? 4'b0101 : 4'b0100));
            end
        end
    endtask

    task automatic test_glitch();
        DataIn = 2'b00;
        for (int e = 1; e <= 7; e++) begin
            if (e == 3) DataIn = 2'b01;
            tick();
            checks++;
            if (DataOut[0] !== 1'b1 || FallPulse[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch_reject edge %0d: got out=%b fall=%b required out=1 fall=0", e, DataOut[0], FallPulse[0]);
            end
        end
        DataIn = 2'b00;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if ({DataOut[0], FallPulse[0]} !== ((e < 5) ? 2'b10 : (e == 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL glitch_fall edge %0d: got %b required %b", e, {DataOut[0], FallPulse[0]}, ((e < 5) ? 2'b10 : (e == 5) ? 2'b01 : 2'b00));
            end
        end
    endtask

    task automatic test_slow_tick();
        int rises;
        rises = 0;
        settle(2'b00);
        DataIn = 2'b10;
        for (int e = 0; e < 24; e++) begin
            CountEnable = (e % 4 == 0);
            tick();
            if (RisePulse[1]) rises++;
            checks++;
            if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== {mOut, mRise, mFall, mRep}) begin
                failures++;
                $display("[TB] FAIL slow_tick edge %0d: got %b required %b", e, {DataOut, RisePulse, FallPulse, RepeatPulse}, {mOut, mRise, mFall, mRep});
            end
        end
        checks++;
        if (rises != 1 || DataOut !== 2'b10) begin
            failures++;
            $display("[TB] FAIL slow_tick_result: got rises=%0d out=%b required rises=1 out=10", rises, DataOut);
        end
        CountEnable = 1'b1;
    endtask

    task automatic test_simultaneous();
        settle(2'b00);
        DataIn = 2'b11;
        repeat (5) tick();
        checks++;
        if ({DataOut, RisePulse} !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL simultaneous_rise: got %b required %b", {DataOut, RisePulse}, 4'b1111);
        end
        settle(2'b00);
        DataIn = 2'b11;
        repeat (4) tick();
        Reset = 1'b0;
        resetModel();
        #1;
        checks++;
        if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_mid_window: got %b required %b", {DataOut, RisePulse, FallPulse, RepeatPulse}, 8'h00);
        end
        #1;
        Reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== {mOut, mRise, mFall, mRep}) begin
                failures++;
                $display("[TB] FAIL after_reset edge %0d: got %b required %b", e, {DataOut, RisePulse, FallPulse, RepeatPulse}, {mOut, mRise, mFall, mRep});
            end
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 400; e++) begin
            if ($urandom_range(3) == 0) DataIn[$urandom_range(CH - 1)] ^= 1'b1;
            CountEnable = ($urandom_range(3) != 0);
            tick();
            checks++;
            if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== {mOut, mRise, mFall, mRep}) begin
                failures++;
                $display("[TB] FAIL random edge %0d: got %b required %b", e, {DataOut, RisePulse, FallPulse, RepeatPulse}, {mOut, mRise, mFall, mRep});
            end
        end
        CountEnable = 1'b1;
    endtask

    task automatic test_repeat();
        int sinceRise;
        sinceRise = -1;
        settle(2'b00);
        DataIn = 2'b01;
        for (int e = 0; e < 20; e++) begin
            if (e == 14) DataIn = 2'b00;
            tick();
            if (RisePulse[0]) sinceRise = 0;
            else if (sinceRise >= 0) sinceRise++;
            checks++;
            if ({DataOut, RisePulse, FallPulse, RepeatPulse} !== {mOut, mRise, mFall, mRep}) begin
                failures++;
                $display("[TB] FAIL repeat_model edge %0d: got %b required %b", e, {DataOut, RisePulse, FallPulse, RepeatPulse}, {mOut, mRise, mFall, mRep});
            end
`ifdef DEBOUNCE_REPEAT_EN
            checks++;
            if (RepeatPulse[0] !== (DataOut[0] && sinceRise >= RD && (sinceRise - RD) % RP == 0)) begin
                failures++;
                $display("[TB] FAIL repeat_timing edge %0d: got %b required %b", e, RepeatPulse[0], (DataOut[0] && sinceRise >= RD && (sinceRise - RD) % RP == 0));
            end
`else
            checks++;
            if (RepeatPulse !== 2'b00) begin
                failures++;
                $display("[TB] FAIL repeat_tied_off edge %0d: got %b required 00", e, RepeatPulse);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_slow_tick();
        test_simultaneous();
        test_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
